// File: rtl/dac_tx_q14.sv
// dac_tx_q14: saturates a signed Q9.14 sample, converts it to a 12-bit
// offset-binary code and shifts it out as a 16-bit SYNC/SCLK/DIN frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// REPOSO | idle, listo=1, accepts a sample
// ENVIO  | sync_n low, 16 bits shifted MSB first, one bit per SCLK period
// ESPERA | sync_n high quiet time of one SCLK period before idling
module dac_tx_q14 #(
  parameter int ancho_p  = 23,
  parameter int magnitud = 8,
  parameter int fraccion = 14,
  parameter int bits_dac = 12,
  parameter int div_sclk = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ancho_p-1:0] dato_in,
  input  logic               dato_valido,
  output logic               listo,
  output logic               perdido,
  output logic               saturado,
  output logic               sclk,
  output logic               sync_n,
  output logic               sdata,
  output logic               fin_trama
);

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] ENVIO  = 2'd1;
  localparam logic [1:0] ESPERA = 2'd2;

  localparam int TOP = fraccion + magnitud;
  localparam int SH  = fraccion + 1 - bits_dac;
  localparam int CW  = $clog2(2 * div_sclk) + 1;

  localparam logic signed [ancho_p-1:0] MAX_V = ancho_p'((2 ** fraccion) - 1);
  localparam logic signed [ancho_p-1:0] MIN_V = ~MAX_V;

  localparam logic [CW-1:0] CNT_FASE   = CW'(div_sclk - 1);
  localparam logic [CW-1:0] CNT_ESPERA = CW'(2 * div_sclk - 1);

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic [3:0]                bit_cnt;
  logic [15:0]               sh_reg;

  logic signed [ancho_p-1:0] muestra;
  logic signed [ancho_p-1:0] sat;
  logic                      desborde;
  logic [bits_dac-1:0]       code_2c;
  logic [bits_dac-1:0]       code;
  logic [15:0]               frame;
  logic                      acepta;

  // Clamp to [-2^fraccion, 2^fraccion-1]: overflow when the integer bits
  // plus the sign are not a pure sign extension.
  always_comb begin
    muestra  = dato_in;
    desborde = !((&dato_in[TOP:fraccion]) || !(|dato_in[TOP:fraccion]));
    if (desborde)
      sat = dato_in[ancho_p-1] ? MIN_V : MAX_V;
    else
      sat = muestra;
    code_2c = bits_dac'(sat >>> SH);
    // Adding 2^(bits_dac-1) to a two's-complement value of that width
    // is just an MSB flip.
    code    = {~code_2c[bits_dac-1], code_2c[bits_dac-2:0]};
    frame   = 16'(code);
  end

  assign acepta = dato_valido && listo;

  // Frame sequencer; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REPOSO;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh_reg    <= '0;
      listo     <= 1'b1;
      perdido   <= 1'b0;
      saturado  <= 1'b0;
      sclk      <= 1'b1;
      sync_n    <= 1'b1;
      sdata     <= 1'b0;
      fin_trama <= 1'b0;
    end else begin
      perdido   <= dato_valido && !listo;
      fin_trama <= 1'b0;
      case (state)
        REPOSO: begin
          if (acepta) begin
            state    <= ENVIO;
            listo    <= 1'b0;
            saturado <= desborde;
            sync_n   <= 1'b0;
            sclk     <= 1'b1;
            sdata    <= frame[15];
            sh_reg   <= {frame[14:0], 1'b0};
            bit_cnt  <= 4'd15;
            cnt      <= CNT_FASE;
          end
        end
        ENVIO: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sclk) begin
            sclk <= 1'b0;
            cnt  <= CNT_FASE;
          end else if (bit_cnt == 4'd0) begin
            state  <= ESPERA;
            sync_n <= 1'b1;
            sclk   <= 1'b1;
            sdata  <= 1'b0;
            cnt    <= CNT_ESPERA;
          end else begin
            sclk    <= 1'b1;
            sdata   <= sh_reg[15];
            sh_reg  <= {sh_reg[14:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
            cnt     <= CNT_FASE;
          end
        end
        ESPERA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= REPOSO;
            listo     <= 1'b1;
            fin_trama <= 1'b1;
          end
        end
        default: begin
          state  <= REPOSO;
          listo  <= 1'b1;
          sclk   <= 1'b1;
          sync_n <= 1'b1;
          sdata  <= 1'b0;
        end
      endcase
    end
  end

endmodule
